// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: register map, CTRL field layout and scan FSM states
package seg7_scan_ctrl_pkg;
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_DPMASK = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam int CTRL_ON_BIT = 0;
    localparam int CTRL_BRI_LSB = 4;
    localparam int CTRL_BRI_W = 4;
    localparam int CTRL_BLANK_LSB = 8;
    typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: CPU data bus as seen by the display peripheral
interface seg7_scan_ctrl_if;
    logic enable;
    logic rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    modport master(output enable, rw, addr, data, input rdata);
    modport slave(input enable, rw, addr, data, output rdata);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: hex nibble to active-low segment pattern, bit 0 = a .. bit 6 = g
module seg7_hex_decode (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: bus-mapped multiplexed 7-segment scanner with guard interval, PWM and frame snapshot
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h10,
    parameter int NDIGITS = 4,
    parameter int PRESCALE_BITS = 6,
    parameter int DWELL_TICKS = 16,
    parameter int GUARD_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    seg7_scan_ctrl_if.slave bus,
    output logic [7:0] seg,
    output logic [NDIGITS-1:0] an,
    output logic frame_strobe
);
    localparam int DW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
    localparam int GW = $clog2(GUARD_TICKS + 1);
    localparam int WW = $clog2(DWELL_TICKS);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NDIGITS - 1);
    localparam logic [GW-1:0] LAST_GUARD = GW'(GUARD_TICKS - 1);
    localparam logic [WW-1:0] LAST_DWELL = WW'(DWELL_TICKS - 1);

    logic [4*NDIGITS-1:0] data_r, shadow_data;
    logic [NDIGITS-1:0] dp_r, shadow_dp, blank_r;
    logic on_r;
    logic [CTRL_BRI_W-1:0] bri_r;
    logic [31:0] off, rd_val;
    logic in_range, wr_en, rd_en;
    logic [PRESCALE_BITS-1:0] pcnt;
    logic tick;
    state_t state, state_n;
    logic [DW-1:0] digit, digit_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [WW-1:0] dwell, dwell_n;
    logic wrap, load, lit;
    logic [3:0] nibble;
    logic [6:0] hex_seg;
    logic unused_data;

    assign off = bus.addr - BASE;
    assign in_range = off < 32'd3;
    assign wr_en = bus.enable && bus.rw && in_range;
    assign rd_en = bus.enable && !bus.rw && in_range;
    assign unused_data = ^bus.data;

    always_comb rd_val = off[1:0] == REG_DATA ? 32'(data_r) :
                         off[1:0] == REG_DPMASK ? 32'(dp_r) :
                         (32'(blank_r) << CTRL_BLANK_LSB) | (32'(bri_r) << CTRL_BRI_LSB) | (32'(on_r) << CTRL_ON_BIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= '0;
            dp_r <= '0;
            on_r <= 1'b1;
            bri_r <= '1;
            blank_r <= '0;
            bus.rdata <= '0;
        end else begin
            bus.rdata <= rd_en ? rd_val : '0;
            if (wr_en && off[1:0] == REG_DATA) data_r <= bus.data[4*NDIGITS-1:0];
            if (wr_en && off[1:0] == REG_DPMASK) dp_r <= bus.data[NDIGITS-1:0];
            if (wr_en && off[1:0] == REG_CTRL) begin
                on_r <= bus.data[CTRL_ON_BIT];
                bri_r <= bus.data[CTRL_BRI_LSB +: CTRL_BRI_W];
                blank_r <= bus.data[CTRL_BLANK_LSB +: NDIGITS];
            end
        end
    end

    assign tick = &pcnt;

    always_comb begin
        state_n = state;
        digit_n = digit;
        gcnt_n = gcnt;
        dwell_n = dwell;
        wrap = 1'b0;
        load = 1'b0;
        if (tick) begin
            if (!on_r) begin
                state_n = IDLE;
            end else if (state == IDLE) begin
                state_n = GUARD;
                digit_n = '0;
                gcnt_n = '0;
                load = 1'b1;
            end else if (state == GUARD) begin
                state_n = gcnt == LAST_GUARD ? DRIVE : GUARD;
                gcnt_n = gcnt == LAST_GUARD ? gcnt : gcnt + 1'b1;
                dwell_n = '0;
            end else if (dwell == LAST_DWELL) begin
                state_n = GUARD;
                gcnt_n = '0;
                wrap = digit == LAST_DIGIT;
                load = wrap;
                digit_n = wrap ? '0 : digit + 1'b1;
            end else begin
                dwell_n = dwell + 1'b1;
            end
        end
    end

    // brightness is read live so PWM duty changes take effect mid-frame
    assign lit = state == DRIVE && 32'(dwell) < 32'(bri_r) && !blank_r[digit];
    assign nibble = shadow_data[4*digit +: 4];

    seg7_hex_decode u_hex (
        .hex(nibble),
        .seg(hex_seg)
    );

    // an/seg come from the settled state register, so they switch together one clk later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            state <= GUARD;
            digit <= '0;
            gcnt <= '0;
            dwell <= '0;
            shadow_data <= '0;
            shadow_dp <= '0;
            frame_strobe <= 1'b0;
            an <= '1;
            seg <= 8'hFF;
        end else begin
            pcnt <= pcnt + 1'b1;
            state <= state_n;
            digit <= digit_n;
            gcnt <= gcnt_n;
            dwell <= dwell_n;
            frame_strobe <= wrap;
            if (load) begin
                shadow_data <= data_r;
                shadow_dp <= dp_r;
            end
            an <= lit ? ~(NDIGITS'(1) << digit) : '1;
            seg <= lit ? {~shadow_dp[digit], hex_seg} : 8'hFF;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and randomized checks against a frame-position reference model
module tb_seg7_scan_ctrl;
    localparam logic [31:0] BASE = 32'h10;
    localparam int TICK = 4;
    localparam int GUARD = 2;
    localparam int DWELL = 16;
    localparam int SLOT = GUARD + DWELL;
    localparam int FRAME = 4 * SLOT;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] seg;
    logic [3:0] an;
    logic fs;
    int tests = 0;
    int fails = 0;

    seg7_scan_ctrl_if bus();

    seg7_scan_ctrl #(.BASE(BASE), .NDIGITS(4), .PRESCALE_BITS(2), .DWELL_TICKS(DWELL), .GUARD_TICKS(GUARD)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .seg(seg),
        .an(an),
        .frame_strobe(fs)
    );

    always #5 clk = ~clk;

    // reference model: position in the frame measured in ticks, -1 while idle
    logic [15:0] m_data, m_sdata;
    logic [3:0] m_dp, m_sdp, m_bri, m_blank;
    logic m_on, m_tick;
    int m_cyc, m_pos;
    logic [31:0] m_off;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic e_fs;
    logic [31:0] e_rdata;

    assign m_tick = (m_cyc % TICK) == TICK - 1;
    assign m_off = bus.addr - BASE;

    function automatic logic is_lit(int p);
        if (p < 0) return 1'b0;
        if (p % SLOT < GUARD) return 1'b0;
        if (p % SLOT - GUARD >= int'(m_bri)) return 1'b0;
        return !m_blank[p / SLOT];
    endfunction

    function automatic logic [3:0] exp_an(int p);
        return is_lit(p) ? ~(4'b1 << (p / SLOT)) : 4'hF;
    endfunction

    function automatic logic [7:0] exp_seg(int p);
        int d;
        d = p < 0 ? 0 : p / SLOT;
        return is_lit(p) ? {~m_sdp[d], HEX[m_sdata[4*d +: 4]]} : 8'hFF;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= '0;
            m_dp <= '0;
            m_on <= 1'b1;
            m_bri <= 4'hF;
            m_blank <= '0;
            m_sdata <= '0;
            m_sdp <= '0;
            m_cyc <= 0;
            m_pos <= 0;
            e_an <= 4'hF;
            e_seg <= 8'hFF;
            e_fs <= 1'b0;
            e_rdata <= '0;
        end else begin
            m_cyc <= m_cyc + 1;
            e_an <= exp_an(m_pos);
            e_seg <= exp_seg(m_pos);
            e_fs <= m_tick && m_on && m_pos == FRAME - 1;
            if (m_tick) m_pos <= !m_on ? -1 : (m_pos < 0 ? 0 : (m_pos + 1) % FRAME);
            if (m_tick && m_on && (m_pos < 0 || m_pos == FRAME - 1)) begin
                m_sdata <= m_data;
                m_sdp <= m_dp;
            end
            if (bus.enable && bus.rw && m_off == 0) m_data <= bus.data[15:0];
            if (bus.enable && bus.rw && m_off == 1) m_dp <= bus.data[3:0];
            if (bus.enable && bus.rw && m_off == 2) begin
                m_on <= bus.data[0];
                m_bri <= bus.data[7:4];
                m_blank <= bus.data[11:8];
            end
            e_rdata <= !(bus.enable && !bus.rw) ? 32'h0 :
                       m_off == 0 ? {16'h0, m_data} :
                       m_off == 1 ? {28'h0, m_dp} :
                       m_off == 2 ? {20'h0, m_blank, m_bri, 3'b0, m_on} : 32'h0;
        end
    end

    int act_cnt [4];
    logic [7:0] last_seg [4];
    int gap, min_gap;
    logic seen_act;
    logic [3:0] prev_an = 4'hF;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        for (int d = 0; d < 4; d++) begin
            act_cnt[d] = 0;
            last_seg[d] = 8'h00;
        end
        gap = 0;
        min_gap = 9999;
        seen_act = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("frame_strobe", fs, e_fs);
        chk("rdata", bus.rdata, e_rdata);
        chk("one_anode", $countones(~an) <= 1, 1);
        for (int d = 0; d < 4; d++) begin
            if (an == ~(4'b1 << d)) begin
                act_cnt[d]++;
                last_seg[d] = seg;
            end
        end
        if (an != 4'hF && prev_an != 4'hF && an != prev_an) min_gap = 0;
        if (an == 4'hF) gap++;
        else begin
            if (seen_act && gap > 0 && gap < min_gap) min_gap = gap;
            seen_act = 1'b1;
            gap = 0;
        end
        prev_an = an;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        bus.enable = 1'b1;
        bus.rw = 1'b1;
        bus.addr = a;
        bus.data = d;
        step();
        bus.enable = 1'b0;
        bus.rw = 1'b0;
    endtask

    task automatic rd(logic [31:0] a, logic [31:0] exp);
        bus.enable = 1'b1;
        bus.rw = 1'b0;
        bus.addr = a;
        step();
        chk($sformatf("read@%0h", a), bus.rdata, exp);
        bus.enable = 1'b0;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (fs !== 1'b1 && n < 1000);
        chk("strobe_seen", fs, 1);
    endtask

    initial begin
        int n;
        logic [31:0] rv;
        bus.enable = 1'b0;
        bus.rw = 1'b0;
        bus.addr = '0;
        bus.data = '0;
        clr_stats();
        repeat (3) step();
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_fs", fs, 0);
        chk("rst_rdata", bus.rdata, 0);
        reset = 1'b0;
        rd(BASE + 2, 32'h0000_00F1);
        rd(BASE + 3, 32'h0);
        rd(BASE, 32'h0);
        rd(BASE - 1, 32'h0);
        // basic display of 1234 at full brightness
        wr(BASE, 32'h1234);
        wait_strobe(n);
        clr_stats();
        wait_strobe(n);
        chk("period", n, 288);
        chk("d0_seg", last_seg[0], 8'h99);
        chk("d3_seg", last_seg[3], 8'hF9);
        chk("d0_on", act_cnt[0], 60);
        chk("guard_gap", min_gap >= 8, 1);
        // brightness 4 and 0
        wr(BASE + 2, 32'h41);
        wait_strobe(n);
        clr_stats();
        wait_strobe(n);
        for (int d = 0; d < 4; d++) chk($sformatf("bri4_d%0d", d), act_cnt[d], 16);
        wr(BASE + 2, 32'h01);
        wait_strobe(n);
        clr_stats();
        wait_strobe(n);
        chk("bri0_dark", act_cnt[0] + act_cnt[1] + act_cnt[2] + act_cnt[3], 0);
        // mid-frame update is deferred to the next frame
        wr(BASE + 2, 32'hF1);
        wait_strobe(n);
        repeat (100) step();
        clr_stats();
        wr(BASE, 32'hFFFF);
        wait_strobe(n);
        chk("old_d3", last_seg[3], 8'hF9);
        clr_stats();
        wait_strobe(n);
        chk("new_d0", last_seg[0], 8'h8E);
        // switch off and back on
        repeat (100) step();
        wr(BASE + 2, 32'hF0);
        repeat (5) step();
        chk("off_an", an, 4'hF);
        chk("off_seg", seg, 8'hFF);
        clr_stats();
        repeat (300) step();
        chk("off_dark", act_cnt[0] + act_cnt[1] + act_cnt[2] + act_cnt[3], 0);
        wr(BASE + 2, 32'hF1);
        n = 0;
        while (an === 4'hF && n < 40) begin
            step();
            n++;
        end
        chk("restart_d0", an, 4'b1110);
        // blank digit 2
        wr(BASE + 2, 32'h4F1);
        wait_strobe(n);
        clr_stats();
        wait_strobe(n);
        chk("blank_d2", act_cnt[2], 0);
        chk("blank_d1", act_cnt[1], 60);
        // randomized register contents checked cycle by cycle against the model
        repeat (8) begin
            rv = $urandom;
            wr(BASE, rv);
            rd(BASE, rv & 32'hFFFF);
            rv = $urandom;
            wr(BASE + 1, rv);
            rd(BASE + 1, rv & 32'hF);
            rv = $urandom;
            rv[0] = $urandom_range(0, 3) != 0;
            wr(BASE + 2, rv);
            rd(BASE + 2, rv & 32'hFF1);
            rd(BASE + $urandom_range(3, 9), 32'h0);
            repeat ($urandom_range(50, 400)) step();
        end
        // asynchronous reset while a digit is driven
        wr(BASE + 2, 32'hF1);
        n = 0;
        while (an === 4'hF && n < 300) begin
            step();
            n++;
        end
        chk("drive_seen", an !== 4'hF, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_an", an, 4'hF);
        chk("async_seg", seg, 8'hFF);
        chk("async_fs", fs, 0);
        repeat (2) step();
        reset = 1'b0;
        rd(BASE + 2, 32'h0000_00F1);
        rd(BASE + 3, 32'h0);
        repeat (20) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
